parity_frame_ctrl: RTL and testbench

//  Sequences the 4-bit XOR parity reduction over a frame of nibbles streamed in by valid/ready.

---
 rtl/parity_frame_ctrl.sv | 122 ++++++++++++
 tb/tb_parity_frame_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// Frame-level XOR parity checker for a valid/ready nibble stream.
// Reports pass/fail as a done pulse, held result flags and timed LEDs.
module parity_frame_ctrl #(
    parameter int MAX_NIBBLES = 16,
    parameter bit ODD_PARITY  = 1'b0,
    parameter int HOLD_CYCLES = 12_000_000,
    localparam int CW = $clog2(MAX_NIBBLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          nib_valid,
    input  logic [3:0]    nib_data,
    input  logic          nib_last,
    input  logic          par_bit,
    output logic          nib_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          len_err,
    output logic [CW-1:0] nib_cnt,
    output logic          led_ok,
    output logic          led_err
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CHECK,
        REPORT
    } state_t;

    state_t        state;
    logic          acc;
    logic          par_q;
    logic          len_flag;
    logic [HW-1:0] hold;
    logic          xfer;
    logic          res_err;

    assign nib_ready = (state == ACCUM);
    assign busy      = (state == ACCUM) || (state == CHECK);
    assign xfer      = nib_valid & nib_ready;
    assign res_err   = len_flag | (acc ^ par_q ^ ODD_PARITY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= 1'b0;
            par_q    <= 1'b0;
            len_flag <= 1'b0;
            hold     <= '0;
            nib_cnt  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            len_err  <= 1'b0;
            led_ok   <= 1'b0;
            led_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= ACCUM;
                        acc      <= 1'b0;
                        nib_cnt  <= '0;
                        len_flag <= 1'b0;
                    end
                end
                ACCUM: begin
                    // A restart discards any nibble offered in the same cycle.
                    if (frame_start) begin
                        acc      <= 1'b0;
                        nib_cnt  <= '0;
                        len_flag <= 1'b0;
                    end else if (xfer) begin
                        acc <= acc ^ (^nib_data);
                        if (nib_cnt != CW'(MAX_NIBBLES))
                            nib_cnt <= nib_cnt + 1'b1;
                        if (nib_last) begin
                            par_q <= par_bit;
                            state <= CHECK;
                        end else if (nib_cnt == CW'(MAX_NIBBLES - 1)) begin
                            len_flag <= 1'b1;
                            state    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    done    <= 1'b1;
                    err     <= res_err;
                    len_err <= len_flag;
                    led_ok  <= ~res_err;
                    led_err <= res_err;
                    hold    <= '0;
                    state   <= REPORT;
                end
                REPORT: begin
                    // A new frame preempts the LED hold; result flags persist.
                    if (frame_start) begin
                        led_ok   <= 1'b0;
                        led_err  <= 1'b0;
                        acc      <= 1'b0;
                        nib_cnt  <= '0;
                        len_flag <= 1'b0;
                        state    <= ACCUM;
                    end else if (hold == HW'(HOLD_CYCLES - 1)) begin
                        led_ok  <= 1'b0;
                        led_err <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: frame vector table with a result scoreboard.
// Hand sequences cover reset mid-frame, restart and report preemption.
module tb_parity_frame_ctrl;

    localparam int MAXN = 4;
    localparam int HOLD = 5;
    localparam int CW   = $clog2(MAXN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          nib_valid;
    logic [3:0]    nib_data;
    logic          nib_last;
    logic          par_bit;
    logic          nib_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic          len_err;
    logic [CW-1:0] nib_cnt;
    logic          led_ok;
    logic          led_err;

    parity_frame_ctrl #(
        .MAX_NIBBLES(MAXN),
        .ODD_PARITY (1'b0),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .nib_last   (nib_last),
        .par_bit    (par_bit),
        .nib_ready  (nib_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .len_err    (len_err),
        .nib_cnt    (nib_cnt),
        .led_ok     (led_ok),
        .led_err    (led_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          n;
        bit          last;
        bit          par;
        bit          e_err;
        bit          e_len;
    } vec_t;

    typedef struct {
        bit err;
        bit len;
        int cnt;
    } exp_t;

    exp_t q[$];
    vec_t vecs[7];
    int   ncmp = 0;
    int   nfail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        exp_t e;
        e.err = v.e_err;
        e.len = v.e_len;
        e.cnt = v.n;
        q.push_back(e);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cnt_after_start", nib_cnt, 0);
    endtask

    task automatic beats(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            chk("ready_in_accum", nib_ready, 1);
            nib_valid = 1'b1;
            nib_data  = v.d[i*4 +: 4];
            nib_last  = v.last && (i == v.n - 1);
            par_bit   = v.par;
            tick();
        end
        nib_valid = 1'b0;
        nib_last  = 1'b0;
        par_bit   = 1'b0;
    endtask

    task automatic await_done(input bit hold_chk);
        int   k;
        exp_t e;
        k = 0;
        chk("ready_low_check", nib_ready, 0);
        chk("busy_in_check", busy, 1);
        while (done !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        chk("done_latency", k, 1);
        if (done !== 1'b1) return;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = q.pop_front();
        chk("err", err, e.err);
        chk("len_err", len_err, e.len);
        chk("nib_cnt", nib_cnt, e.cnt);
        chk("led_ok", led_ok, !e.err);
        chk("led_err", led_err, e.err);
        chk("busy_in_report", busy, 0);
        if (!hold_chk) return;
        tick();
        chk("done_one_cycle", done, 0);
        for (int i = 1; i < HOLD - 1; i++) tick();
        chk("led_ok_last_hold", led_ok, !e.err);
        chk("led_err_last_hold", led_err, e.err);
        tick();
        chk("led_ok_after_hold", led_ok, 0);
        chk("led_err_after_hold", led_err, 0);
        chk("err_held", err, e.err);
        chk("idle_not_ready", nib_ready, 0);
    endtask

    initial begin
        vecs[0] = '{16'h003A, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0071, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0071, 2, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h18EF, 4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h9642, 4, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{16'h0007, 1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst         = 1'b1;
        frame_start = 1'b0;
        nib_valid   = 1'b0;
        nib_data    = 4'h0;
        nib_last    = 1'b0;
        par_bit     = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", nib_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", nib_cnt, 0);
        chk("rst_leds", {led_ok, led_err}, 0);
        rst = 1'b0;
        tick();

        for (int f = 0; f < 7; f++) begin
            start(vecs[f]);
            beats(vecs[f]);
            await_done(1'b1);
        end

        // reset in the middle of a frame
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        nib_valid = 1'b1;
        nib_data  = 4'h1;
        tick();
        nib_data  = 4'h2;
        tick();
        nib_valid = 1'b0;
        chk("pre_rst_cnt", nib_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", nib_ready, 0);
        chk("midrst_cnt", nib_cnt, 0);
        chk("midrst_flags", {done, err, len_err, led_ok, led_err}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_done", done, 0);
        end
        start(vecs[0]);
        beats(vecs[0]);
        await_done(1'b1);

        // restart wins over a simultaneous nibble
        start(vecs[6]);
        nib_valid = 1'b1;
        nib_data  = 4'h1;
        tick();
        chk("restart_pre_cnt", nib_cnt, 1);
        frame_start = 1'b1;
        nib_data    = 4'hF;
        nib_last    = 1'b1;
        tick();
        frame_start = 1'b0;
        nib_valid   = 1'b0;
        nib_last    = 1'b0;
        chk("restart_cnt", nib_cnt, 0);
        chk("restart_ready", nib_ready, 1);
        beats(vecs[6]);
        await_done(1'b0);

        // new frame preempts the LED hold
        chk("pre_preempt_led", led_ok, 1);
        start(vecs[2]);
        chk("preempt_led_ok", led_ok, 0);
        chk("preempt_led_err", led_err, 0);
        chk("preempt_err_kept", err, 0);
        beats(vecs[2]);
        await_done(1'b1);

        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
